// File: rtl/pwm_multichannel_if.sv
// Byte-wide register write port driven by the SPI register front end.
interface pwm_multichannel_if;
   localparam int unsigned ADDR_W = 7;
   localparam int unsigned DATA_W = 8;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (output wr_en, wr_addr, wr_data);
   modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/pwm_multichannel.sv
// Multichannel PWM: shared prescaled counter (edge or center aligned) and
// per-channel enables and double-buffered duty. Shadows load at period ends.
module pwm_multichannel #(
   parameter int unsigned NUM_CH = 16,
   parameter int unsigned RES    = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   pwm_multichannel_if.slave  bus,
   output logic [NUM_CH-1:0]  out,
   output logic               period_tick
);
   localparam logic [RES-1:0] MAX      = RES'((1 << RES) - 1);
   localparam logic [RES-1:0] TOP      = MAX - RES'(1);
   localparam logic [6:0]     PRESC_A  = 7'h08;
   localparam logic [6:0]     CTRL_A   = 7'h09;

   logic [7:0]     presc;
   logic [7:0]     pcnt;
   logic           run;
   logic           mode;
   logic [RES-1:0] cnt;
   logic           dir_down;

   logic           wr_ctrl_c;
   logic           mode_chg_c;
   logic           tick_c;
   logic           boundary_c;
   logic           load_c;

   // Shared decode: counter tick, period boundary and duty load strobe.
   always_comb begin
      wr_ctrl_c  = bus.wr_en && (bus.wr_addr == CTRL_A);
      mode_chg_c = wr_ctrl_c && (bus.wr_data[1] != mode);
      tick_c     = run && (pcnt == presc);
      boundary_c = tick_c && !mode_chg_c &&
                   (mode ? (dir_down && (cnt == '0)) : (cnt == TOP));
      load_c     = boundary_c || !run;
   end

   // Global control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         run   <= 1'b0;
         mode  <= 1'b0;
      end else begin
         if (bus.wr_en && (bus.wr_addr == PRESC_A)) presc <= bus.wr_data;
         if (wr_ctrl_c) begin
            run  <= bus.wr_data[0];
            mode <= bus.wr_data[1];
         end
      end
   end

   // Prescaler and counter; a mode switch restarts the period silently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt        <= '0;
         cnt         <= '0;
         dir_down    <= 1'b0;
         period_tick <= 1'b0;
      end else begin
         period_tick <= boundary_c;
         if (!run || mode_chg_c) begin
            pcnt     <= '0;
            cnt      <= '0;
            dir_down <= 1'b0;
         end else begin
            // >= also recovers when presc was lowered below the running count
            pcnt <= (pcnt >= presc) ? '0 : pcnt + 8'd1;
            if (tick_c) begin
               if (!mode) begin
                  cnt <= (cnt == TOP) ? '0 : cnt + RES'(1);
               end else if (!dir_down) begin
                  if (cnt == TOP) dir_down <= 1'b1;
                  else            cnt      <= cnt + RES'(1);
               end else begin
                  if (cnt == '0) dir_down <= 1'b0;
                  else           cnt      <= cnt - RES'(1);
               end
            end
         end
      end
   end

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      localparam logic [6:0]  EN_A   = 7'(ch / 8);
      localparam logic [6:0]  PWM_A  = 7'(4 + ch / 8);
      localparam logic [6:0]  DUTY_A = 7'(64 + ch);
      localparam int unsigned BIT    = ch % 8;

      logic           en;
      logic           pwm;
      logic [RES-1:0] shadow;
      logic [RES-1:0] shadow_nxt;
      logic [RES-1:0] active;

      // Write-through view of the shadow so a boundary-cycle write is loaded.
      always_comb begin
         shadow_nxt = shadow;
         if (bus.wr_en && (bus.wr_addr == DUTY_A)) shadow_nxt = bus.wr_data[RES-1:0];
      end

      // Per-channel enables, duty buffers and registered output.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            en      <= 1'b0;
            pwm     <= 1'b0;
            shadow  <= '0;
            active  <= '0;
            out[ch] <= 1'b0;
         end else begin
            if (bus.wr_en && (bus.wr_addr == EN_A))  en  <= bus.wr_data[BIT];
            if (bus.wr_en && (bus.wr_addr == PWM_A)) pwm <= bus.wr_data[BIT];
            shadow <= shadow_nxt;
            if (load_c) active <= shadow_nxt;
            out[ch] <= en && (!pwm || (run && ((active == MAX) || (cnt < active))));
         end
      end
   end
endmodule

// File: tb/tb_pwm_multichannel.sv
// Self-checking bench: DUT A (16 ch, 8 bit) and DUT B (20 ch, 4 bit).
module tb_pwm_multichannel;
   logic        clk;
   logic        rst_n;
   logic [15:0] out_a;
   logic [19:0] out_b;
   logic        tick_a;
   logic        tick_b;

   pwm_multichannel_if if_a ();
   pwm_multichannel_if if_b ();

   pwm_multichannel #(.NUM_CH(16), .RES(8)) u_a (
      .clk(clk), .rst_n(rst_n), .bus(if_a), .out(out_a), .period_tick(tick_a));
   pwm_multichannel #(.NUM_CH(20), .RES(4)) u_b (
      .clk(clk), .rst_n(rst_n), .bus(if_b), .out(out_b), .period_tick(tick_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard: expectations queued with stimulus, popped on measurement
   string sb_name[$];
   int    sb_val[$];
   int    n_chk  = 0;
   int    n_fail = 0;

   function automatic void expect_val(input string name, input int val);
      sb_name.push_back(name);
      sb_val.push_back(val);
   endfunction

   function automatic void check(input int act);
      string nm;
      int    ev;
      n_chk++;
      if (sb_val.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_underflow: got %0d with nothing expected", act);
         return;
      end
      nm = sb_name.pop_front();
      ev = sb_val.pop_front();
      if (act != ev) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, ev);
      end
   endfunction

   task automatic wr(input bit b, input logic [6:0] a, input logic [7:0] d);
      @(negedge clk);
      if (b) begin
         if_b.wr_en = 1'b1; if_b.wr_addr = a; if_b.wr_data = d;
      end else begin
         if_a.wr_en = 1'b1; if_a.wr_addr = a; if_a.wr_data = d;
      end
      @(negedge clk);
      if_a.wr_en = 1'b0;
      if_b.wr_en = 1'b0;
   endtask

   // samples until period_tick; n = samples taken, -1 on timeout
   task automatic wait_tick(input bit b, input int limit, output int n);
      logic t;
      n = 0;
      do begin
         @(posedge clk); #1;
         t = b ? tick_b : tick_a;
         n++;
      end while (!t && n < limit);
      if (!t) n = -1;
   endtask

   logic hist [512];

   // one period window starting right after a period_tick sample
   task automatic period(input bit b, input logic [4:0] ch, output int hi, output int len);
      logic [19:0] all;
      logic        t;
      hi  = 0;
      len = 0;
      do begin
         @(posedge clk); #1;
         all = b ? out_b : {4'b0, out_a};
         t   = b ? tick_b : tick_a;
         if (len < 512) hist[len] = all[ch];
         len++;
         if (all[ch] === 1'b1) hi++;
      end while (!t && len < 600);
   endtask

   typedef struct packed {
      logic [6:0]  addr;
      logic [7:0]  data;
      logic [15:0] exp;
   } vec_t;

   vec_t vt [8];
   int   hi, len, n, cnt_lo, cnt_x, cnt_stray, f10, l10;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{addr: 7'h00, data: 8'hFF, exp: 16'h00FF};
      vt[1] = '{addr: 7'h00, data: 8'h00, exp: 16'h0000};
      vt[2] = '{addr: 7'h00, data: 8'hA5, exp: 16'h00A5};
      vt[3] = '{addr: 7'h04, data: 8'h0F, exp: 16'h00A0};
      vt[4] = '{addr: 7'h04, data: 8'h00, exp: 16'h00A5};
      vt[5] = '{addr: 7'h10, data: 8'hFF, exp: 16'h00A5};
      vt[6] = '{addr: 7'h01, data: 8'h3C, exp: 16'h3CA5};
      vt[7] = '{addr: 7'h00, data: 8'h00, exp: 16'h3C00};

      if_a.wr_en = 1'b0; if_a.wr_addr = '0; if_a.wr_data = '0;
      if_b.wr_en = 1'b0; if_b.wr_addr = '0; if_b.wr_data = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      expect_val("reset_out_a", 0);    check(int'(out_a));
      expect_val("reset_tick_a", 0);   check(int'(tick_a));
      expect_val("reset_out_b", 0);    check(int'(out_b));
      @(negedge clk);
      rst_n = 1'b1;

      // static enables with run=0, one cycle after each write
      for (int i = 0; i < 8; i++) begin
         expect_val($sformatf("vec%0d_out", i), int'(vt[i].exp));
         wr(1'b0, vt[i].addr, vt[i].data);
         @(posedge clk); #1;
         check(int'(out_a));
      end

      // edge mode, duty 128 of 255
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      wr(1'b0, 7'h00, 8'h01);
      wr(1'b0, 7'h04, 8'h01);
      wr(1'b0, 7'h40, 8'd128);
      wr(1'b0, 7'h08, 8'h00);
      wr(1'b0, 7'h09, 8'h01);
      expect_val("t1_first_tick_found", 1);
      wait_tick(1'b0, 600, n);
      check(n > 0 ? 1 : 0);
      for (int p = 0; p < 2; p++) begin
         expect_val($sformatf("t1_p%0d_high", p), 128);
         expect_val($sformatf("t1_p%0d_len", p), 255);
         period(1'b0, 5'd0, hi, len);
         check(hi);
         check(len);
      end
      expect_val("t1_out0_before_reset", 1);
      @(posedge clk); #1;
      check(int'(out_a[0]));
      #2 rst_n = 1'b0;
      #1;
      expect_val("t1_async_reset_out", 0);
      check(int'(out_a));
      @(negedge clk); rst_n = 1'b1;

      // mid-period and boundary-cycle duty writes on channel 3
      wr(1'b0, 7'h00, 8'h09);
      wr(1'b0, 7'h04, 8'h09);
      wr(1'b0, 7'h43, 8'd64);
      wr(1'b0, 7'h09, 8'h01);
      expect_val("t3_first_tick_found", 1);
      wait_tick(1'b0, 600, n);
      check(n > 0 ? 1 : 0);
      expect_val("t3_mid_write_keeps_64", 64);
      fork
         period(1'b0, 5'd3, hi, len);
         begin repeat (100) @(negedge clk); wr(1'b0, 7'h43, 8'd200); end
      join
      check(hi);
      expect_val("t3_next_period_200", 200);
      fork
         period(1'b0, 5'd3, hi, len);
         begin repeat (254) @(negedge clk); wr(1'b0, 7'h43, 8'd10); end
      join
      check(hi);
      expect_val("t3_boundary_write_10", 10);
      period(1'b0, 5'd3, hi, len);
      check(hi);

      // duty 0 and duty MAX over three whole periods each
      wr(1'b0, 7'h43, 8'd0);
      period(1'b0, 5'd3, hi, len);
      for (int p = 0; p < 3; p++) begin
         expect_val($sformatf("t4_duty0_p%0d_high", p), 0);
         period(1'b0, 5'd3, hi, len);
         check(hi);
      end
      wr(1'b0, 7'h43, 8'd255);
      period(1'b0, 5'd3, hi, len);
      for (int p = 0; p < 3; p++) begin
         expect_val($sformatf("t4_dutymax_p%0d_high", p), 255);
         expect_val($sformatf("t4_dutymax_p%0d_len", p), 255);
         period(1'b0, 5'd3, hi, len);
         check(hi);
         check(len);
      end

      // center mode, RES=4, presc=1, duty 5
      wr(1'b1, 7'h00, 8'h01);
      wr(1'b1, 7'h04, 8'h01);
      wr(1'b1, 7'h40, 8'd5);
      wr(1'b1, 7'h08, 8'd1);
      wr(1'b1, 7'h09, 8'h03);
      expect_val("t5_first_tick_found", 1);
      wait_tick(1'b1, 200, n);
      check(n > 0 ? 1 : 0);
      expect_val("t5_len", 60);
      expect_val("t5_high", 20);
      expect_val("t5_high_first10", 10);
      expect_val("t5_high_last10", 10);
      period(1'b1, 5'd0, hi, len);
      f10 = 0;
      l10 = 0;
      if (len >= 10 && len <= 512) begin
         for (int i = 0; i < 10; i++) begin
            if (hist[i] === 1'b1) f10++;
            if (hist[len-10+i] === 1'b1) l10++;
         end
      end
      check(len);
      check(hi);
      check(f10);
      check(l10);
      // mode switch mid-period: edge period of 30 clocks restarts from 0
      repeat (20) @(negedge clk);
      wr(1'b1, 7'h09, 8'h01);
      expect_val("t5_restart_to_tick", 30);
      wait_tick(1'b1, 200, n);
      check(n);

      // upper byte channels and ignored addresses
      wr(1'b1, 7'h09, 8'h00);
      for (int c = 16; c < 20; c++) wr(1'b1, 7'(64 + c), 8'd15);
      wr(1'b1, 7'h02, 8'hFF);
      wr(1'b1, 7'h06, 8'hFF);
      wr(1'b1, 7'h09, 8'h01);
      @(posedge clk); #1;
      expect_val("t6_out_19_16", 15);
      check(int'(out_b[19:16]));
      wr(1'b1, 7'h03, 8'h00);
      wr(1'b1, 7'h59, 8'h00);
      cnt_lo = 0;
      cnt_x = 0;
      cnt_stray = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_b[19:16] !== 4'hF) cnt_lo++;
         if ($isunknown(out_b)) cnt_x++;
         if (out_b[15:1] !== 15'h0) cnt_stray++;
      end
      expect_val("t6_upper_low_samples", 0);
      expect_val("t6_x_samples", 0);
      expect_val("t6_stray_samples", 0);
      check(cnt_lo);
      check(cnt_x);
      check(cnt_stray);

      n_chk++;
      if (sb_val.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_leftover: got %0d pending, expected 0", sb_val.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
